rr_reg_arbiter: RTL
===================

# rr_reg_arbiter

Round-robin arbiter and sequencer that shares a single W-bit storage register, built from positive-edge flip-flops with clear, among N requesters. Each requester asks for ownership, the arbiter grants exactly one at a time, and only the owner may load the register. A hold limit bounds each ownership. The block sits between the lab datapath's producer units and the shared state register they would otherwise contend for.

## Interface
- N, 4, number of requesters (>=1)
- W, 8, width of the shared register
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership (>=1)

- clock  input  1  single clock; all state updates on posedge
- clearb  input  1  asynchronous, active-low reset; low forces all state to reset values immediately
- req  input  N  req[i] high = requester i wants or keeps ownership
- we  input  N  we[i] high = requester i loads the register this cycle
- wdata  input  N*W  requester i data is wdata[i*W +: W]
- gnt  output  N  registered one-hot grant, or all zero
- q  output  W  shared register contents
- owner  output  clog2(N) (min 1)  index of the requester that last loaded q
- busy  output  1  high while any grant is active (equals |gnt)

## Operation
- Reset values (clearb low): gnt=0, q=0, owner=0, busy=0, FSM=IDLE, priority pointer ptr=0, hold counter=0.
- FSM states: IDLE, OWN, GAP.
- IDLE: if req!=0, pick first i with req[i]=1, searching circularly from ptr (ptr, ptr+1, ... mod N). At the edge, set gnt[i]=1, busy=1, hold counter=1, go to OWN. If req==0, stay.
- OWN (owner k):
  - Load: if req[k] & we[k], q <= wdata slice k and owner <= k at the edge.
  - we from any non-granted requester is ignored.
  - Voluntary release: if req[k]=0 at an edge, there is no load. Set gnt=0 and ptr=(k+1) mod N, then go to GAP.
  - Forced release: if req[k]=1 and hold counter==MAX_HOLD, a load in that cycle is still accepted. Set gnt=0 and ptr=(k+1) mod N, then go to GAP.
  - Otherwise, increment the hold counter and stay in OWN.
- GAP: exactly one cycle with gnt=0. Requests are ignored. Go to IDLE.
- ptr advances only on release, so every requester holding req high is granted within N ownerships.
- N=1: ptr stays at 0 and the forced-release and GAP rules still apply.
- q holds its value whenever no load occurs, including during IDLE and GAP.

## Timing
- All outputs are registered. There are no combinational paths from input to output.
- Request to grant: req sampled at edge t (FSM in IDLE) gives gnt high in the cycle after edge t.
- Write latency: a qualified we/wdata at edge t makes q and owner update in the cycle after edge t.
- Grant length: gnt stays high for at most MAX_HOLD cycles per ownership.
- Release to next grant: at least 2 cycles, one of GAP and one of IDLE sampling, so gnt is zero for at least 2 cycles between ownerships.
- Simultaneous requests in IDLE: the circular scan from ptr decides. The lowest circular distance from ptr wins.
- Owner drops req and raises we in the same cycle: the release wins and there is no load.
- clearb asserted mid-ownership: gnt, q, owner and busy go to 0 immediately, without waiting for a clock edge.
- After clearb deasserts, the first grant is possible at the first clock edge.

## Test plan
- Reset: hold clearb low with req=4'b1111 and random we/wdata -> gnt=0, q=0, owner=0, busy=0 throughout. Release clearb with req=4'b0100 -> gnt=4'b0100 after the next edge.
- Single owner write: req[2]=1, then we[2]=1 with slice 2 = 8'hA5 for 1 cycle -> q=8'hA5 and owner=2 one cycle later. we[0]=1 with slice 0 = 8'h3C at the same time -> q is not affected.
- Rotation: req=4'b1111 held constantly, MAX_HOLD=8 -> grants go to 0,1,2,3,0. Each gnt is high for exactly 8 cycles with a 2-cycle zero gap between grants.
- Voluntary release and priority: requester 1 owns and drops req after 3 cycles while req[0]=req[3]=1 -> the next grant goes to 3 (ptr=2 scans 2,3), then to 0.
- Release with write: the owner drops req in the same cycle as we=1 with data 8'hFF -> q keeps its prior value and gnt is 0 the next cycle.
- Async reset mid-grant: during OWN with q=8'h5A, pulse clearb low between clock edges -> gnt, q, owner and busy are 0 before the next posedge, and the FSM restarts in IDLE with ptr=0.

Source files
------------

// File: rtl/rr_reg_arbiter_if.sv
// Bus between the requesters and the round-robin register arbiter.
// Requesters drive req/we/wdata; the arbiter returns grant, register and status.
interface rr_reg_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [OW-1:0]  owner;
  logic           busy;

  modport master (
    output req, we, wdata,
    input  gnt, q, owner, busy
  );

  modport slave (
    input  req, we, wdata,
    output gnt, q, owner, busy
  );
endinterface

// File: rtl/rr_reg_arbiter.sv
// Round-robin arbiter guarding one shared W-bit register: one owner at a time,
// bounded hold time, one-cycle gap after every release.
module rr_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic             clock,
  input  logic             clearb,
  rr_reg_arbiter_if.slave  bus
);
  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

  state_t        state_reg, state_next;
  logic [OW-1:0] ptr_reg, ptr_next;
  logic [OW-1:0] cur_reg, cur_next;
  logic [OW-1:0] owner_reg, owner_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic [W-1:0]  q_reg, q_next;
  logic          busy_reg, busy_next;

  logic          found;
  logic [OW-1:0] pick;
  logic [OW-1:0] cand;
  logic [W-1:0]  slice [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign slice[gi] = bus.wdata[gi*W +: W];
    end
  endgenerate

  // Circular scan starting at ptr; the first requester found wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int d = 0; d < N; d++) begin
      cand = OW'((int'(ptr_reg) + d) % N);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    cur_next   = cur_reg;
    owner_next = owner_reg;
    hold_next  = hold_reg;
    gnt_next   = gnt_reg;
    q_next     = q_reg;
    busy_next  = busy_reg;
    case (state_reg)
      IDLE: begin
        if (found) begin
          gnt_next       = '0;
          gnt_next[pick] = 1'b1;
          cur_next       = pick;
          hold_next      = HW'(1);
          busy_next      = 1'b1;
          state_next     = OWN;
        end
      end
      OWN: begin
        // A dropped request releases without loading, even if we is high.
        if (bus.req[cur_reg] && bus.we[cur_reg]) begin
          q_next     = slice[cur_reg];
          owner_next = cur_reg;
        end
        if (!bus.req[cur_reg] || hold_reg == HW'(MAX_HOLD)) begin
          gnt_next   = '0;
          busy_next  = 1'b0;
          hold_next  = '0;
          ptr_next   = OW'((int'(cur_reg) + 1) % N);
          state_next = GAP;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cur_reg   <= '0;
      owner_reg <= '0;
      hold_reg  <= '0;
      gnt_reg   <= '0;
      q_reg     <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      cur_reg   <= cur_next;
      owner_reg <= owner_next;
      hold_reg  <= hold_next;
      gnt_reg   <= gnt_next;
      q_reg     <= q_next;
      busy_reg  <= busy_next;
    end
  end

  assign bus.gnt   = gnt_reg;
  assign bus.q     = q_reg;
  assign bus.owner = owner_reg;
  assign bus.busy  = busy_reg;
endmodule
